// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
// Responder end of the multiplexed address/data RTC bus (active-low A_D, CS,
// WR, RD). Decodes address, write and read cycles against a 16 x 8 register
// file, drives read data back through ad_out/ad_oe (the top level builds the
// tristate), and offers a host port so local logic can update registers.
//
// Ports
//   Clock_in, Reset            system clock, synchronous active-high reset
//   A_D, CS, WR, RD, ad_in     asynchronous bus inputs from the controller
//   ad_out, ad_oe              read data and its output enable
//   host_we/addr/wdata/rdata   host register access, rdata registered
//   wr_strobe, rd_strobe       1-cycle pulses on bus write commit / read end
//   proto_err                  1-cycle pulse on a protocol violation
//
// state | meaning
// IDLE  | no address latched yet
// ADDR  | address cycle in progress, shadowing the bus value
// ARMED | address latched, waiting for a data or new address cycle
// WRITE | write data cycle in progress, shadowing the bus value
// READ  | read data cycle, ad_out driven
module rtc_bus_responder (
   input  logic       Clock_in,
   input  logic       Reset,
   input  logic       A_D,
   input  logic       CS,
   input  logic       WR,
   input  logic       RD,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic       host_we,
   input  logic [3:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic [7:0] host_rdata,
   output logic       wr_strobe,
   output logic       rd_strobe,
   output logic       proto_err
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ARMED, S_WRITE, S_READ} state_t;

   state_t state, state_nxt;

   logic       a_m, a_s, cs_m, cs_s, wr_m, wr_s, rd_m, rd_s;
   logic [7:0] d_m, d_s;
   logic       cs_p, wr_p, rd_p;
   logic       cs_rel, wr_rel, rd_rel, addr_cyc;

   logic [7:0] addr_shadow, addr_reg, data_shadow;
   logic [7:0] regs     [16];
   logic [7:0] regs_nxt [16];
   logic       in_range;
   logic       err_p;

   logic       addr_commit, bus_commit, rd_go, rd_done, err_cond;

   // Synchronisers idle at the bus rest level so reset never looks like a cycle.
   always_ff @(posedge Clock_in) begin
      if (Reset) begin
         a_m  <= 1'b1;  a_s  <= 1'b1;
         cs_m <= 1'b1;  cs_s <= 1'b1;
         wr_m <= 1'b1;  wr_s <= 1'b1;
         rd_m <= 1'b1;  rd_s <= 1'b1;
         d_m  <= 8'h00; d_s  <= 8'h00;
         cs_p <= 1'b1;  wr_p <= 1'b1;  rd_p <= 1'b1;
      end else begin
         a_m  <= A_D;   a_s  <= a_m;
         cs_m <= CS;    cs_s <= cs_m;
         wr_m <= WR;    wr_s <= wr_m;
         rd_m <= RD;    rd_s <= rd_m;
         d_m  <= ad_in; d_s  <= d_m;
         cs_p <= cs_s;  wr_p <= wr_s;  rd_p <= rd_s;
      end
   end

   assign cs_rel   = ~cs_p & cs_s;
   assign wr_rel   = ~wr_p & wr_s;
   assign rd_rel   = ~rd_p & rd_s;
   assign addr_cyc = ~cs_s & ~wr_s & ~a_s;
   assign in_range = (addr_reg[7:4] == 4'h0);

   always_ff @(posedge Clock_in) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      addr_commit = 1'b0;
      bus_commit  = 1'b0;
      rd_go       = 1'b0;
      rd_done     = 1'b0;
      err_cond    = 1'b0;
      case (state)
         S_IDLE: begin
            if (addr_cyc)
               state_nxt = S_ADDR;
            else if (~cs_s & a_s & (~wr_s | ~rd_s))
               err_cond = 1'b1;
         end
         S_ADDR: begin
            if (cs_rel | wr_rel) begin
               addr_commit = 1'b1;
               state_nxt   = S_ARMED;
            end
         end
         S_ARMED: begin
            if (addr_cyc)
               state_nxt = S_ADDR;
            else if (~cs_s & a_s & ~wr_s & ~rd_s)
               err_cond = 1'b1;
            else if (~cs_s & a_s & ~wr_s)
               state_nxt = S_WRITE;
            else if (~cs_s & a_s & ~rd_s) begin
               rd_go     = 1'b1;
               state_nxt = S_READ;
            end
         end
         S_WRITE: begin
            if (wr_rel | cs_rel) begin
               bus_commit = 1'b1;
               state_nxt  = S_ARMED;
            end
         end
         S_READ: begin
            if (rd_rel | cs_rel) begin
               rd_done   = 1'b1;
               state_nxt = S_ARMED;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus write is applied after the host write so it wins on a collision.
   always_comb begin
      regs_nxt = regs;
      if (host_we)
         regs_nxt[host_addr] = host_wdata;
      if (bus_commit && in_range)
         regs_nxt[addr_reg[3:0]] = data_shadow;
   end

   always_ff @(posedge Clock_in) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
         addr_shadow <= 8'h00;
         addr_reg    <= 8'h00;
         data_shadow <= 8'h00;
         ad_out      <= 8'h00;
         ad_oe       <= 1'b0;
         host_rdata  <= 8'h00;
         wr_strobe   <= 1'b0;
         rd_strobe   <= 1'b0;
         proto_err   <= 1'b0;
         err_p       <= 1'b0;
      end else begin
         regs       <= regs_nxt;
         host_rdata <= regs_nxt[host_addr];
         if (state == S_ADDR)  addr_shadow <= d_s;
         if (addr_commit)      addr_reg    <= addr_shadow;
         if (state == S_WRITE) data_shadow <= d_s;
         if (rd_go) begin
            ad_oe  <= 1'b1;
            ad_out <= in_range ? regs[addr_reg[3:0]] : 8'h00;
         end else if (rd_done) begin
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
         end
         wr_strobe <= bus_commit;
         rd_strobe <= rd_done;
         // One pulse per violation even while the bad level is held.
         err_p     <= err_cond;
         proto_err <= err_cond & ~err_p;
      end
   end

endmodule

// File: tb/tb_rtc_bus_responder.sv
module tb_rtc_bus_responder;

   logic       Clock_in = 1'b0;
   logic       Reset    = 1'b1;
   logic       A_D = 1'b1, CS = 1'b1, WR = 1'b1, RD = 1'b1;
   logic [7:0] ad_in = 8'h00;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic       host_we = 1'b0;
   logic [3:0] host_addr = 4'h0;
   logic [7:0] host_wdata = 8'h00;
   logic [7:0] host_rdata;
   logic       wr_strobe, rd_strobe, proto_err;

   rtc_bus_responder dut (
      .Clock_in  (Clock_in),
      .Reset     (Reset),
      .A_D       (A_D),
      .CS        (CS),
      .WR        (WR),
      .RD        (RD),
      .ad_in     (ad_in),
      .ad_out    (ad_out),
      .ad_oe     (ad_oe),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_wdata(host_wdata),
      .host_rdata(host_rdata),
      .wr_strobe (wr_strobe),
      .rd_strobe (rd_strobe),
      .proto_err (proto_err)
   );

   always #5 Clock_in = ~Clock_in;

   int cyc = 0;
   always @(posedge Clock_in) cyc <= cyc + 1;

   localparam int EV_OE = 1, EV_OEOFF = 2, EV_WR = 3, EV_RD = 4,
                  EV_ERR = 5, EV_HOST = 6, EV_QUIET = 7;

   typedef struct {
      int          kind;
      logic [15:0] data;
      int          at;
      string       name;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  probe_kind = 0;

   task automatic expect_ev(input int kind, input logic [15:0] data, input int at,
                            input string name);
      ev_t e;
      e.kind = kind; e.data = data; e.at = at; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic score(input int kind, input logic [15:0] act);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_event: actual kind=%0d data=%h cycle=%0d, required no event",
                  kind, act, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== act || (e.at >= 0 && e.at != cyc)) begin
         n_bad++;
         $display("FAIL %s: actual kind=%0d data=%h cycle=%0d, required kind=%0d data=%h cycle=%0d",
                  e.name, kind, act, cyc, e.kind, e.data, e.at);
      end
   endtask

   // Monitor: samples 1 ns after the falling edge, pops expectations per event.
   initial begin
      logic       oe_prev;
      logic [7:0] held;
      oe_prev = 1'b0;
      held    = 8'h00;
      forever begin
         @(negedge Clock_in);
         #1;
         if (oe_prev && !ad_oe) score(EV_OEOFF, 16'h0000);
         if (!oe_prev && ad_oe) begin
            score(EV_OE, {8'h00, ad_out});
            held = ad_out;
         end else if (oe_prev && ad_oe) begin
            n_cmp++;
            if (ad_out !== held) begin
               n_bad++;
               $display("FAIL read_data_stable: actual %h, required %h at cycle %0d",
                        ad_out, held, cyc);
            end
         end
         if (wr_strobe) score(EV_WR, 16'h0000);
         if (rd_strobe) score(EV_RD, 16'h0000);
         if (proto_err) score(EV_ERR, 16'h0000);
         if (probe_kind == EV_HOST)
            score(EV_HOST, {8'h00, host_rdata});
         else if (probe_kind == EV_QUIET)
            score(EV_QUIET, {ad_out, 4'h0, ad_oe, wr_strobe, rd_strobe, proto_err});
         oe_prev = ad_oe;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clock_in);
   endtask

   task automatic probe(input int kind, input logic [3:0] a, input logic [15:0] exp_v,
                        input string name);
      host_addr = a;
      tick(2);
      expect_ev(kind, exp_v, cyc, name);
      probe_kind = kind;
      tick(1);
      probe_kind = 0;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      tick(1);
      host_we    = 1'b0;
      tick(1);
   endtask

   task automatic bus_addr(input logic [7:0] a);
      A_D = 1'b0; ad_in = a; CS = 1'b0; WR = 1'b0;
      tick(6);
      WR = 1'b1; CS = 1'b1;
      tick(2);
      A_D = 1'b1; ad_in = 8'h00;
      tick(3);
   endtask

   // Optional host write timed to land on the same edge as the bus commit.
   task automatic bus_write(input logic [7:0] d, input bit collide, input logic [3:0] ha,
                            input logic [7:0] hd, input string name);
      ad_in = d; CS = 1'b0; WR = 1'b0;
      tick(6);
      WR = 1'b1; CS = 1'b1;
      expect_ev(EV_WR, 16'h0000, cyc + 3, name);
      tick(2);
      if (collide) begin
         host_addr = ha; host_wdata = hd; host_we = 1'b1;
      end
      tick(1);
      host_we = 1'b0;
      ad_in   = 8'h00;
      tick(3);
   endtask

   task automatic bus_read(input logic [7:0] d, input string name);
      ad_in = 8'h00; CS = 1'b0; RD = 1'b0;
      expect_ev(EV_OE, {8'h00, d}, cyc + 3, {name, "_oe_on"});
      tick(8);
      RD = 1'b1; CS = 1'b1;
      expect_ev(EV_OEOFF, 16'h0000, cyc + 3, {name, "_oe_off"});
      expect_ev(EV_RD, 16'h0000, cyc + 3, {name, "_rd_strobe"});
      tick(5);
   endtask

   initial begin
      tick(3);
      Reset = 1'b0;
      tick(2);

      probe(EV_QUIET, 4'h0, 16'h0000, "reset_outputs");
      probe(EV_HOST,  4'h0, 16'h0000, "reset_reg0");
      probe(EV_HOST,  4'hF, 16'h0000, "reset_reg15");

      // Data cycle straight from IDLE.
      A_D = 1'b1; CS = 1'b0; WR = 1'b0; ad_in = 8'h3C;
      expect_ev(EV_ERR, 16'h0000, cyc + 3, "proto_err_idle");
      tick(6);
      CS = 1'b1; WR = 1'b1; ad_in = 8'h00;
      tick(4);

      bus_addr(8'h05);
      bus_write(8'hA7, 1'b0, 4'h0, 8'h00, "write_reg5_strobe");
      probe(EV_HOST, 4'h5, 16'h00A7, "host_read_reg5");

      host_write(4'h3, 8'h59);
      probe(EV_HOST, 4'h3, 16'h0059, "host_write_reg3");
      bus_addr(8'h03);
      bus_read(8'h59, "read_reg3");
      bus_read(8'h59, "reread_reg3");

      bus_addr(8'h20);
      bus_write(8'hFF, 1'b0, 4'h0, 8'h00, "oor_write_strobe");
      bus_read(8'h00, "oor_read");
      probe(EV_HOST, 4'h0, 16'h0000, "oor_no_wrap_reg0");
      probe(EV_HOST, 4'h5, 16'h00A7, "oor_keep_reg5");
      probe(EV_HOST, 4'h3, 16'h0059, "oor_keep_reg3");

      // WR and RD low together while ARMED.
      bus_addr(8'h07);
      CS = 1'b0; WR = 1'b0; RD = 1'b0; ad_in = 8'h99;
      expect_ev(EV_ERR, 16'h0000, cyc + 3, "proto_err_armed");
      tick(6);
      CS = 1'b1; WR = 1'b1; RD = 1'b1; ad_in = 8'h00;
      tick(4);
      probe(EV_HOST, 4'h7, 16'h0000, "armed_err_no_write");

      bus_write(8'h22, 1'b1, 4'h7, 8'h11, "collision_strobe");
      probe(EV_HOST, 4'h7, 16'h0022, "collision_bus_wins");

      // Reset while a read is driving the bus.
      bus_addr(8'h05);
      ad_in = 8'h00; CS = 1'b0; RD = 1'b0;
      expect_ev(EV_OE, 16'h00A7, cyc + 3, "pre_reset_read_oe_on");
      tick(6);
      Reset = 1'b1;
      expect_ev(EV_OEOFF, 16'h0000, cyc + 1, "reset_drops_oe");
      tick(1);
      RD = 1'b1; CS = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick(2);
      probe(EV_HOST,  4'h5, 16'h0000, "reset_clears_reg5");
      probe(EV_HOST,  4'h7, 16'h0000, "reset_clears_reg7");
      probe(EV_QUIET, 4'h0, 16'h0000, "post_reset_outputs");
      bus_addr(8'h00);
      bus_read(8'h00, "post_reset_read0");

      tick(10);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: actual %0d outstanding, required 0 (next %s)",
                  exp_q.size(), exp_q[0].name);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
